// File: rtl/ppu_pkg.sv
// Shared PPU pixel-path types and constants.
// Used by the background shifter, the pixel mux and its bus interface.
package ppu_pkg;

   typedef logic [3:0] pixel_t;     // {palette[1:0], color[1:0]}
   typedef logic [4:0] pal_addr_t;  // palette RAM address

   localparam pal_addr_t SPR_PAL_BASE   = 5'h10;
   localparam logic [7:0] LEFT_CLIP_COLS = 8'd8;

   // Color index 0 of any palette is transparent.
   function automatic logic is_opaque(input pixel_t px);
      return px[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/pixel_mux_if.sv
// Pixel mux bus: tile feed, dot position, mask enables and sprite pixel in,
// palette address and sprite-0 hit out.
interface pixel_mux_if;
   import ppu_pkg::*;

   logic       ce;
   logic       bg_load;
   logic       bg_shift;
   logic [7:0] pat_lo;
   logic [7:0] pat_hi;
   logic [1:0] attr;
   logic [2:0] fine_x;
   logic [7:0] pixel_x;
   logic       visible;
   logic       show_bg;
   logic       show_spr;
   logic       bg_left;
   logic       spr_left;
   pixel_t     spr_pixel;
   logic       spr_behind;
   logic       spr_is_zero;
   logic       spr0_clr;
   pal_addr_t  pal_addr;
   logic       pal_valid;
   logic       spr0_hit;

   modport master (
      output ce, bg_load, bg_shift, pat_lo, pat_hi, attr, fine_x, pixel_x,
             visible, show_bg, show_spr, bg_left, spr_left, spr_pixel,
             spr_behind, spr_is_zero, spr0_clr,
      input  pal_addr, pal_valid, spr0_hit
   );

   modport slave (
      input  ce, bg_load, bg_shift, pat_lo, pat_hi, attr, fine_x, pixel_x,
             visible, show_bg, show_spr, bg_left, spr_left, spr_pixel,
             spr_behind, spr_is_zero, spr0_clr,
      output pal_addr, pal_valid, spr0_hit
   );

endinterface

// File: rtl/pixel_mux_bg_shifter.sv
// Background tile shifters: two 16-bit pattern planes and two 8-bit attribute
// planes fed from a 2-bit latch; fine_x picks the output column.
module bg_shifter
   import ppu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   input  logic       bg_load,
   input  logic       bg_shift,
   input  logic [7:0] pat_lo,
   input  logic [7:0] pat_hi,
   input  logic [1:0] attr,
   input  logic [2:0] fine_x,
   output pixel_t     bg_pixel
);

   logic [1:0] latch_reg;
   logic [1:0] pat_bit;
   logic [1:0] attr_bit;
   logic [2:0] attr_idx;
   logic [3:0] pat_idx;

   // 7-fine_x and 15-fine_x without width-changing arithmetic.
   assign attr_idx = ~fine_x;
   assign pat_idx  = {1'b1, ~fine_x};

   always_ff @(posedge clk) begin
      if (reset) begin
         latch_reg <= 2'b00;
      end else if (ce && bg_load) begin
         latch_reg <= attr;
      end
   end

   // Plane 0 carries the low bits, plane 1 the high bits.
   for (genvar gi = 0; gi < 2; gi++) begin : g_plane
      logic [15:0] pat_reg, pat_next;
      logic [7:0]  attr_reg, attr_next;
      logic [7:0]  tile;

      assign tile = (gi == 0) ? pat_lo : pat_hi;

      // Shift happens first so a simultaneous load lands in the fresh low byte.
      always_comb begin
         pat_next  = pat_reg;
         attr_next = attr_reg;
         if (bg_shift) begin
            pat_next  = {pat_reg[14:0], 1'b0};
            attr_next = {attr_reg[6:0], latch_reg[gi]};
         end
         if (bg_load) begin
            pat_next[7:0] = tile;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            pat_reg  <= '0;
            attr_reg <= '0;
         end else if (ce) begin
            pat_reg  <= pat_next;
            attr_reg <= attr_next;
         end
      end

      assign pat_bit[gi]  = pat_reg[pat_idx];
      assign attr_bit[gi] = attr_reg[attr_idx];
   end

   assign bg_pixel = {attr_bit[1], attr_bit[0], pat_bit[1], pat_bit[0]};

endmodule

// File: rtl/pixel_mux.sv
// PPU pixel mux: masks background and sprite pixels, resolves priority into a
// registered palette address, and tracks the sticky sprite-0 hit flag.
module pixel_mux
   import ppu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   pixel_mux_if.slave  bus
);

   pixel_t    bg_raw;
   pixel_t    bg_px;
   pixel_t    spr_px;
   logic      left_zone;
   logic      bg_opq;
   logic      spr_opq;
   logic      hit_set;
   pal_addr_t pal_addr_reg, pal_addr_next;
   logic      pal_valid_reg, pal_valid_next;
   logic      spr0_hit_reg, spr0_hit_next;

   bg_shifter u_bg (
      .clk      (clk),
      .reset    (reset),
      .ce       (bus.ce),
      .bg_load  (bus.bg_load),
      .bg_shift (bus.bg_shift),
      .pat_lo   (bus.pat_lo),
      .pat_hi   (bus.pat_hi),
      .attr     (bus.attr),
      .fine_x   (bus.fine_x),
      .bg_pixel (bg_raw)
   );

   always_comb begin
      left_zone = bus.pixel_x < LEFT_CLIP_COLS;
      bg_px     = (bus.show_bg  && (bus.bg_left  || !left_zone)) ? bg_raw        : 4'h0;
      spr_px    = (bus.show_spr && (bus.spr_left || !left_zone)) ? bus.spr_pixel : 4'h0;
      bg_opq    = is_opaque(bg_px);
      spr_opq   = is_opaque(spr_px);

      pal_addr_next  = 5'h00;
      pal_valid_next = bus.visible;
      if (bus.visible) begin
         if (spr_opq && (!bg_opq || !bus.spr_behind)) begin
            pal_addr_next = SPR_PAL_BASE | {1'b0, spr_px};
         end else if (bg_opq) begin
            pal_addr_next = {1'b0, bg_px};
         end
      end

      // The hit ignores sprite priority; column 255 never registers a hit.
      hit_set       = bus.visible && bg_opq && spr_opq && bus.spr_is_zero &&
                      (bus.pixel_x != 8'd255);
      spr0_hit_next = bus.spr0_clr ? 1'b0 : (spr0_hit_reg | hit_set);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pal_addr_reg  <= 5'h00;
         pal_valid_reg <= 1'b0;
         spr0_hit_reg  <= 1'b0;
      end else if (bus.ce) begin
         pal_addr_reg  <= pal_addr_next;
         pal_valid_reg <= pal_valid_next;
         spr0_hit_reg  <= spr0_hit_next;
      end
   end

   assign bus.pal_addr  = pal_addr_reg;
   assign bus.pal_valid = pal_valid_reg;
   assign bus.spr0_hit  = spr0_hit_reg;

endmodule
